// File: rtl/rcpu_pkg.sv
// rcpu_pkg: definitions shared by the rcpu memory arbiter and its read-tag pipe.
//   WORD_W     : memory word / address width
//   OWNER_*    : identifies which requester issued a read
//   rd_tag_t   : in-flight read tag {valid, owner}
package rcpu_pkg;

  localparam int WORD_W = 16;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

  localparam rd_tag_t TAG_EMPTY = '{valid: 1'b0, owner: OWNER_CPU};

endpackage

// File: rtl/rcpu_rd_tag_pipe.sv
// rcpu_rd_tag_pipe: STAGES-deep shift register of read tags matching the
// memory read latency. A tag entered with a read command emerges on the cycle
// the memory presents that read's data and is decoded into per-owner strobes.
// Ports:
//   clk, i_rst      : clock, synchronous active-high clear (empties all stages)
//   i_tag_valid     : a read command is issued this cycle
//   i_tag_owner     : owner of that read (OWNER_CPU / OWNER_DBG)
//   o_cpu_rvalid    : CPU read data valid this cycle
//   o_dbg_rvalid    : debug read data valid this cycle
module rcpu_rd_tag_pipe
  import rcpu_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_tag_valid,
  input  logic i_tag_owner,
  output logic o_cpu_rvalid,
  output logic o_dbg_rvalid
);

  rd_tag_t r_tag_p [STAGES];
  rd_tag_t w_tag_out;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_tag_p[i] <= TAG_EMPTY;
      end
    end else begin
      r_tag_p[0] <= '{valid: i_tag_valid, owner: i_tag_owner};
      for (int i = 1; i < STAGES; i++) begin
        r_tag_p[i] <= r_tag_p[i-1];
      end
    end
  end

  // Output stage: tags still sitting in the pipe while reset is high are
  // suppressed so a discarded read never produces a strobe.
  assign w_tag_out    = r_tag_p[STAGES-1];
  assign o_cpu_rvalid = ~i_rst & w_tag_out.valid & (w_tag_out.owner == OWNER_CPU);
  assign o_dbg_rvalid = ~i_rst & w_tag_out.valid & (w_tag_out.owner == OWNER_DBG);

endmodule

// File: rtl/rcpu_mem_arbiter.sv
// rcpu_mem_arbiter: shares a single-port memory between the rcpu core (fixed
// priority) and a debug/loader port. A streak counter forces a debug grant
// after MAX_STREAK consecutive CPU grants taken while debug was waiting. Read
// responses are steered back to the issuing requester via a tag pipeline.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata              : CPU command (held until cpu_gnt)
//   cpu_gnt, cpu_stall                 : CPU accepted / CPU waiting
//   cpu_rvalid, cpu_rdata              : CPU read response (rdata holds last value)
//   dbg_req/we/addr/wdata              : debug command (held until dbg_gnt)
//   dbg_gnt                            : debug accepted
//   dbg_rvalid, dbg_rdata              : debug read response (rdata holds last value)
//   mem_en/we/addr/wdata               : memory command, issued in the grant cycle
//   mem_rdata                          : memory data, RD_LATENCY cycles after a read
module rcpu_mem_arbiter
  import rcpu_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [WORD_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [WORD_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [WORD_W-1:0] dbg_addr,
  input  logic [WORD_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [WORD_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  logic [3:0]        r_streak;
  logic [WORD_W-1:0] r_cpu_rdata;
  logic [WORD_W-1:0] r_dbg_rdata;
  logic              w_force_dbg;
  logic              w_cpu_gnt;
  logic              w_dbg_gnt;
  logic              w_rd_issue;
  logic              w_cpu_rvalid;
  logic              w_dbg_rvalid;

  function automatic logic [3:0] streak_sat_inc(input logic [3:0] cur);
    return (cur == STREAK_MAX) ? cur : cur + 4'd1;
  endfunction

  // Grant stage (combinational, same cycle as the request)
  assign w_force_dbg = dbg_req & (r_streak == STREAK_MAX);
  assign w_cpu_gnt   = ~reset & cpu_req & ~w_force_dbg;
  assign w_dbg_gnt   = ~reset & dbg_req & ~w_cpu_gnt;

  assign cpu_gnt   = w_cpu_gnt;
  assign dbg_gnt   = w_dbg_gnt;
  assign cpu_stall = ~reset & cpu_req & ~w_cpu_gnt;

  // Streak only counts CPU wins that actually kept debug waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak <= 4'd0;
    end else if (!dbg_req || w_dbg_gnt) begin
      r_streak <= 4'd0;
    end else if (w_cpu_gnt) begin
      r_streak <= streak_sat_inc(r_streak);
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_dbg_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // Read tag stages: one per cycle of memory read latency
  assign w_rd_issue = mem_en & ~mem_we;

  rcpu_rd_tag_pipe #(
    .STAGES (RD_LATENCY)
  ) u_tag_pipe (
    .clk          (clk),
    .i_rst        (reset),
    .i_tag_valid  (w_rd_issue),
    .i_tag_owner  (w_dbg_gnt ? OWNER_DBG : OWNER_CPU),
    .o_cpu_rvalid (w_cpu_rvalid),
    .o_dbg_rvalid (w_dbg_rvalid)
  );

  // Response stage: deliver mem_rdata on the strobe cycle, then hold it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      if (w_cpu_rvalid) r_cpu_rdata <= mem_rdata;
      if (w_dbg_rvalid) r_dbg_rdata <= mem_rdata;
    end
  end

  assign cpu_rvalid = w_cpu_rvalid;
  assign dbg_rvalid = w_dbg_rvalid;
  assign cpu_rdata  = w_cpu_rvalid ? mem_rdata : r_cpu_rdata;
  assign dbg_rdata  = w_dbg_rvalid ? mem_rdata : r_dbg_rdata;

endmodule
